// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and command layout for the ALU issue stage.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_NOTA = 4'hA;
  localparam logic [3:0] OP_NOTB = 4'hB;
  localparam logic [3:0] OP_LAST = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
  } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO; pointers carry an extra wrap bit for full/empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit combinational ALU: queues commands, drives one at a time,
// captures and error-flags the result, and hands it downstream over valid/ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_y,
  output logic [3:0]       res_sel,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  state_t state;
  cmd_t   head;
  logic   fifo_full, fifo_empty, pop;

  // A pop happens only when the FSM is about to load the ALU registers.
  assign pop       = !fifo_empty && ((state == ST_IDLE) || (state == ST_DONE && res_ready));
  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .wdata ('{a: cmd_a, b: cmd_b, sel: cmd_sel}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_sel   <= '0;
      res_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_valid <= 1'b1;
          res_sel   <= alu_sel;
          // Undefined opcodes never forward the ALU's hold output; divide-by-zero saturates.
          if (alu_sel > OP_LAST) begin
            res_y   <= 8'h00;
            res_err <= 1'b1;
          end else if (alu_sel == OP_DIV && alu_b == 4'h0) begin
            res_y   <= 8'hFF;
            res_err <= 1'b1;
          end else begin
            res_y   <= alu_y;
            res_err <= 1'b0;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            if (!fifo_empty) begin
              alu_a   <= head.a;
              alu_b   <= head.b;
              alu_sel <= head.sel;
              state   <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + randomized bench for alu_op_sequencer with an in-bench ALU and result scoreboard.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, res_ready;
  logic [3:0] cmd_a, cmd_b, cmd_sel;
  logic       cmd_ready, res_valid, res_err, busy;
  logic [3:0] alu_a, alu_b, alu_sel, res_sel;
  logic [7:0] alu_y, res_y;
  logic [7:0] op_count;
  logic       cmd_ready2, res_valid2, res_err2, busy2;
  logic [3:0] alu_a2, alu_b2, alu_sel2, res_sel2;
  logic [7:0] alu_y2, res_y2;
  logic [1:0] op_count2;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  int n_acc = 0;
  logic [11:0] q[$];

  always #5 clk = ~clk;

  // Reference behaviour of the external combinational ALU.
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [7:0] ea, eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (s)
      4'h0: return ea + eb;
      4'h1: return ea - eb;
      4'h2: return ea * eb;
      4'h3: return (b == 4'h0) ? 8'h00 : ea / eb;
      4'h4: return {4'h0, a & b};
      4'h5: return {4'h0, ~(a & b)};
      4'h6: return {4'h0, a | b};
      4'h7: return {4'h0, ~(a | b)};
      4'h8: return {4'h0, a ^ b};
      4'h9: return {4'h0, ~(a ^ b)};
      4'hA: return {4'h0, ~a};
      4'hB: return {4'h0, ~b};
      default: return 8'h55;
    endcase
  endfunction

  // Expected {err, y} for a command.
  function automatic logic [8:0] exp_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    if (s > 4'hB) return {1'b1, 8'h00};
    if (s == 4'h3 && b == 4'h0) return {1'b1, 8'hFF};
    return {1'b0, alu_f(a, b, s)};
  endfunction

  assign alu_y  = alu_f(alu_a, alu_b, alu_sel);
  assign alu_y2 = alu_f(alu_a2, alu_b2, alu_sel2);

  alu_op_sequencer #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_sel(res_sel),
    .res_err(res_err), .busy(busy), .op_count(op_count)
  );

  alu_op_sequencer #(.DEPTH(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2), .alu_y(alu_y2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_y(res_y2), .res_sel(res_sel2),
    .res_err(res_err2), .busy(busy2), .op_count(op_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any handoff before the edge, record any accept, check counters after.
  task automatic tick();
    logic acc, hs;
    logic [11:0] e;
    logic [8:0] ex;
    acc = cmd_valid && cmd_ready;
    hs  = res_valid && res_ready;
    if (hs) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(res_y), 32'h1ff);
      end else begin
        e  = q.pop_front();
        ex = exp_f(e[11:8], e[7:4], e[3:0]);
        chk("res_y", 32'(res_y), 32'(ex[7:0]));
        chk("res_err", 32'(res_err), 32'(ex[8]));
        chk("res_sel", 32'(res_sel), 32'(e[3:0]));
      end
      model_cnt++;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back({cmd_a, cmd_b, cmd_sel});
      n_acc++;
    end
    chk("op_count", 32'(op_count), 32'(model_cnt % 256));
    chk("op_count_w2", 32'(op_count2), 32'(model_cnt % 4));
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (!res_valid) chk({tag, "_timeout"}, 32'(res_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || res_valid) && n < 60) begin
      tick();
      n++;
    end
    if (q.size() != 0 || res_valid) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic set_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
  endtask

  initial begin
    int acc0, cnt0;
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_y", 32'(res_y), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    // ADD with latency check
    res_ready = 1'b1;
    set_cmd(4'hC, 4'hE, 4'h0);
    tick();
    cmd_valid = 1'b0;
    chk("lat_valid_n", 32'(res_valid), 32'd0);
    tick();
    chk("lat_alu_a", 32'(alu_a), 32'hC);
    chk("lat_alu_b", 32'(alu_b), 32'hE);
    chk("lat_alu_sel", 32'(alu_sel), 32'h0);
    chk("lat_valid_n1", 32'(res_valid), 32'd0);
    tick();
    chk("add_valid", 32'(res_valid), 32'd1);
    chk("add_y", 32'(res_y), 32'h1A);
    chk("add_err", 32'(res_err), 32'd0);
    chk("add_sel", 32'(res_sel), 32'h0);
    tick();
    chk("add_busy_after", 32'(busy), 32'd0);
    chk("add_hold_y", 32'(res_y), 32'h1A);

    // MUL
    set_cmd(4'hC, 4'hE, 4'h2);
    tick();
    cmd_valid = 1'b0;
    wait_res("mul");
    chk("mul_y", 32'(res_y), 32'hA8);
    chk("mul_err", 32'(res_err), 32'd0);
    cnt0 = 32'(op_count);
    tick();
    chk("mul_cnt_inc", 32'(op_count), 32'(cnt0 + 1));

    // divide-by-zero then undefined opcode
    set_cmd(4'h5, 4'h0, 4'h3);
    tick();
    set_cmd(4'hC, 4'hE, 4'hD);
    tick();
    cmd_valid = 1'b0;
    wait_res("div0");
    chk("div0_y", 32'(res_y), 32'hFF);
    chk("div0_err", 32'(res_err), 32'd1);
    tick();
    wait_res("opD");
    chk("opD_y", 32'(res_y), 32'h00);
    chk("opD_err", 32'(res_err), 32'd1);
    chk("opD_sel", 32'(res_sel), 32'hD);
    tick();

    // capacity: DEPTH queued + 1 in flight
    res_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 7; i++) begin
      set_cmd(4'(i + 1), 4'(i + 2), 4'(i % 12));
      tick();
    end
    chk("cap_accepted", 32'(n_acc - acc0), 32'd5);
    chk("cap_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("cap_res_hold", 32'(res_valid), 32'd1);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (12) tick();
    chk("cap_all_out", 32'(q.size()), 32'd0);

    // reset mid-EXEC with commands queued
    set_cmd(4'h1, 4'h2, 4'h0); tick();
    set_cmd(4'h3, 4'h4, 4'h1); tick();
    set_cmd(4'h5, 4'h6, 4'h2); tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    q.delete();
    model_cnt = 0;
    chk("mrst_res_valid", 32'(res_valid), 32'd0);
    chk("mrst_res_y", 32'(res_y), 32'd0);
    chk("mrst_res_sel", 32'(res_sel), 32'd0);
    chk("mrst_alu_a", 32'(alu_a), 32'd0);
    chk("mrst_alu_b", 32'(alu_b), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_op_count", 32'(op_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_no_result", 32'(res_valid), 32'd0);
    end
    chk("mrst_idle_busy", 32'(busy), 32'd0);

    // op_count wrap on the CNT_W=2 instance
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      set_cmd(4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)));
      tick();
    end
    drain();
    chk("wrap_accepted", 32'(n_acc - acc0), 32'd5);
    chk("wrap_cnt2", 32'(op_count2), 32'd1);
    chk("wrap_cnt8", 32'(op_count), 32'd5);
    chk("wrap_busy", 32'(busy), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      cmd_a     = 4'($urandom);
      cmd_b     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      cmd_sel   = 4'($urandom_range(0, 15));
      tick();
    end
    drain();
    chk("rand_busy", 32'(busy), 32'd0);
    chk("rand_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
